pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
- Parametrised successor to the single-channel pulse generator: one free-running period counter drives a Sync output and NCH independently timed pulse channels.
- Each channel has its own delay and width, measured in clk cycles from the Sync edge.
- Configuration arrives over a simple register-write port, normally fed by the UART command decoder. It is double-buffered so that changes only take effect at a period boundary.
- Adds a burst mode (N periods, then stop) that the earlier generator does not have.

Parameters:
- NCH, 4, number of pulse channels (1..8).
- CNT_W, 24, width of the period, delay and width counters.
- BURST_W, 16, width of the burst-count register.
- ADDR_W, 5, register address width; must satisfy 2*NCH+4 <= 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, single cycle.
- wr_addr  in  ADDR_W  register address.
- wr_data  in  CNT_W  write data; zero-extended or truncated per register.
- Sync  out  1  period marker.
- Pulse  out  NCH  channel outputs; bit k is channel k.
- busy  out  1  high while in RUN.
- period_done  out  1  one-cycle strobe at the end of each period.

Behaviour:
- Reset (async assert, synchronous release): Sync=0, Pulse=0, busy=0, period_done=0, state=IDLE, all shadow/active registers=0, counter=0.
- Register map (writes land in shadow registers):
  - 0 period
  - 1 sync_width
  - 2 control: bit0 run, bit1 burst_mode
  - 3 burst_count
  - 4+2k delay_k
  - 5+2k width_k
- Unmapped addresses are ignored.
- control.run is self-clearing when a burst completes.
- States:
  - IDLE: counter held at 0, outputs low. When run=1, copy shadow to active and go to RUN on the next cycle.
  - RUN: counter increments each cycle. At cnt==period_eff-1, the counter wraps to 0, period_done pulses, and shadow is copied to active.
  - RUN, burst_mode=1: a burst counter increments at each wrap. When it reaches burst_count, go to IDLE and clear run.
  - RUN, burst_count=0 in burst mode: behaves as a single period.
  - Writing run=0 while in RUN: finish the current period, then go to IDLE. There is no truncated pulse.
- period_eff = max(period, 2).
- Outputs are registered, one cycle behind the counter:
  - Sync = (cnt < sync_width).
  - Pulse[k] = (cnt >= delay_k) && (cnt < delay_k + width_k). The sum is computed at CNT_W+1 bits, so there is no wrap-around.
  - width_k=0 gives a channel that is always low.
  - A channel whose window extends past period_eff is cut at the wrap; it does not spill into the next period.
  - Sync and a channel with delay 0 rise on the same cycle.
- A write in the same cycle as a wrap goes to shadow and is not copied until the following wrap.
- Reset asserted mid-period forces all outputs low immediately (asynchronously).

Optional Feature:
- Macro: PULSE_POLARITY_EN.
- When defined:
  - Register address 2*NCH+4 is an NCH-bit polarity mask, double-buffered like the other registers.
  - Pulse[k] is XORed with mask bit k in RUN.
  - In IDLE, Pulse[k] equals the mask bit, so inactive is the idle level.
  - The reset value of the mask is 0.
- When not defined, the address is unmapped and outputs are active-high.

Decomposition:
- Package pulse_gen_pkg holds:
  - the register address constants: ADDR_PERIOD, ADDR_SYNCW, ADDR_CTRL, ADDR_BURST, ADDR_CH_BASE
  - the control bit indices
  - the state enum {IDLE, RUN}.
- One natural sub-module, pulse_chan: it holds one channel's shadow and active delay/width plus the registered window comparator, and is instantiated NCH times.

Test Plan:
- Continuous mode, period=100, sync_width=10, ch0 delay=20 width=30, run=1:
  - Sync high 10 cycles every 100.
  - Pulse[0] high cycles 20..49 of each period.
  - period_done once per 100 cycles.
- Burst mode, burst_count=3, period=50:
  - exactly 3 Sync pulses, then busy=0 and control.run reads 0
  - Pulse stays low afterwards.
- Mid-run write of ch1 width 5→15 at cycle 37 of a 100-cycle period:
  - current period keeps width 5
  - next period shows width 15.
- Boundary cases:
  - period=1 behaves as 2.
  - width=0 keeps the channel low.
  - delay=90 width=30 with period=100: high for cycles 90..99 only.
  - delay=2^CNT_W-1 width=max: no overflow glitch.
- resetn pulled low mid-pulse:
  - all outputs 0 within the same cycle
  - state returns to IDLE; after release, nothing runs until run is written.
- With PULSE_POLARITY_EN, mask=0b0001:
  - Pulse[0] idles high and goes low during its window
  - other channels are unchanged.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for pulse_gen_multi: register map, control bit positions and FSM states.
package pulse_gen_pkg;

  localparam int ADDR_PERIOD  = 0;
  localparam int ADDR_SYNCW   = 1;
  localparam int ADDR_CTRL    = 2;
  localparam int ADDR_BURST   = 3;
  localparam int ADDR_CH_BASE = 4;  // delay_k at base+2k, width_k at base+2k+1

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_BURST = 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic int ch_delay_addr(input int k);
    return ADDR_CH_BASE + 2 * k;
  endfunction

  function automatic int ch_width_addr(input int k);
    return ADDR_CH_BASE + 2 * k + 1;
  endfunction

endpackage

// File: rtl/pulse_gen_multi_chan.sv
// One pulse channel: shadow/active delay and width plus the registered window comparator.
module pulse_chan #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_delay_i,
  input  logic             wr_width_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             pol_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pulse_o
);

  logic [CNT_W-1:0] delay_sh_q, width_sh_q, delay_q, width_q;
  logic [CNT_W:0]   win_end_s;
  logic             hit_s;
  logic             pulse_q;

  // Window end carries one extra bit so delay+width never wraps back into range.
  assign win_end_s = {1'b0, delay_q} + {1'b0, width_q};
  assign hit_s     = en_i && (cnt_i >= delay_q) && ({1'b0, cnt_i} < win_end_s);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delay_sh_q <= '0;
      width_sh_q <= '0;
      delay_q    <= '0;
      width_q    <= '0;
      pulse_q    <= 1'b0;
    end else begin
      if (wr_delay_i) delay_sh_q <= wr_data_i;
      if (wr_width_i) width_sh_q <= wr_data_i;
      if (load_i) begin
        delay_q <= delay_sh_q;
        width_q <= width_sh_q;
      end
      pulse_q <= hit_s ^ pol_i;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator with double-buffered register writes and burst mode.
// Optional PULSE_POLARITY_EN adds a per-channel output polarity mask register.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 24,
  parameter int BURST_W = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              Sync,
  output logic [NCH-1:0]    Pulse,
  output logic              busy,
  output logic              period_done
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_W:0]     burst_next_s;
  logic [CNT_W-1:0]     period_sh_q, period_q, syncw_sh_q, syncw_q, period_eff_s;
  logic [BURST_W-1:0]   burst_sh_q, burst_q;
  logic                 run_q, burst_mode_sh_q, burst_mode_q;
  logic                 running_s, wrap_s, load_s, run_clr_s;
  logic                 sync_q, done_q, busy_q;
  logic [NCH-1:0]       pol_s;

  assign period_eff_s = (period_q < CNT_W'(2)) ? CNT_W'(2) : period_q;
  assign running_s    = (state_q == RUN);
  assign wrap_s       = running_s && (cnt_q == period_eff_s - CNT_W'(1));
  // Active set tracks shadow throughout IDLE, so it is current when RUN starts.
  assign load_s       = !running_s || wrap_s;
  assign burst_next_s = {1'b0, burst_cnt_q} + {{BURST_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    burst_cnt_d = burst_cnt_q;
    run_clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        burst_cnt_d = '0;
        if (run_q) state_d = RUN;
      end
      RUN: begin
        cnt_d = wrap_s ? '0 : cnt_q + CNT_W'(1);
        if (wrap_s) begin
          if (!run_q) state_d = IDLE;
          if (burst_mode_q) begin
            burst_cnt_d = burst_next_s[BURST_W-1:0];
            if (burst_next_s >= {1'b0, burst_q}) begin
              state_d   = IDLE;
              run_clr_s = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_sh_q     <= '0;
      syncw_sh_q      <= '0;
      burst_sh_q      <= '0;
      burst_mode_sh_q <= 1'b0;
      run_q           <= 1'b0;
      period_q        <= '0;
      syncw_q         <= '0;
      burst_q         <= '0;
      burst_mode_q    <= 1'b0;
    end else begin
      if (run_clr_s) run_q <= 1'b0;
      if (wr_en && wr_addr == ADDR_W'(ADDR_PERIOD)) period_sh_q <= wr_data;
      if (wr_en && wr_addr == ADDR_W'(ADDR_SYNCW))  syncw_sh_q  <= wr_data;
      if (wr_en && wr_addr == ADDR_W'(ADDR_BURST))  burst_sh_q  <= BURST_W'(wr_data);
      if (wr_en && wr_addr == ADDR_W'(ADDR_CTRL)) begin
        run_q           <= wr_data[CTRL_RUN];
        burst_mode_sh_q <= wr_data[CTRL_BURST];
      end
      if (load_s) begin
        period_q     <= period_sh_q;
        syncw_q      <= syncw_sh_q;
        burst_q      <= burst_sh_q;
        burst_mode_q <= burst_mode_sh_q;
      end
    end
  end

`ifdef PULSE_POLARITY_EN
  logic [NCH-1:0] pol_sh_q, pol_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pol_sh_q <= '0;
      pol_q    <= '0;
    end else begin
      if (wr_en && wr_addr == ADDR_W'(ADDR_CH_BASE + 2 * NCH)) pol_sh_q <= NCH'(wr_data);
      if (load_s) pol_q <= pol_sh_q;
    end
  end

  assign pol_s = pol_q;
`else
  assign pol_s = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sync_q <= running_s && (cnt_q < syncw_q);
      done_q <= wrap_s;
      busy_q <= running_s;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    pulse_chan #(.CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .resetn     (resetn),
      .wr_delay_i (wr_en && wr_addr == ADDR_W'(ch_delay_addr(k))),
      .wr_width_i (wr_en && wr_addr == ADDR_W'(ch_width_addr(k))),
      .wr_data_i  (wr_data),
      .load_i     (load_s),
      .en_i       (running_s),
      .pol_i      (pol_s[k]),
      .cnt_i      (cnt_q),
      .pulse_o    (Pulse[k])
    );
  end

  assign Sync        = sync_q;
  assign period_done = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed scoreboard bench for pulse_gen_multi; expected frames come from the period/window formulas.
module tb_pulse_gen_multi;

  localparam int NCH     = 4;
  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic              Sync;
  logic [NCH-1:0]    Pulse;
  logic              busy;
  logic              period_done;

  typedef struct packed {
    logic           sync;
    logic [NCH-1:0] pulse;
    logic           done;
    logic           busy;
  } frame_t;

  frame_t         sb[$];
  int             checks = 0;
  int             failures = 0;
  int             per, syncw, chg_per;
  longint         dly[NCH], wid_a[NCH], wid_b[NCH];
  logic [NCH-1:0] mask;

  always #5 clk = ~clk;

  pulse_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .Sync        (Sync),
    .Pulse       (Pulse),
    .busy        (busy),
    .period_done (period_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected output frames: 'total' running cycles then 'idle_n' idle cycles.
  task automatic push_run(input int total, input int idle_n);
    frame_t f;
    longint pe, jm, w;
    pe = (per < 2) ? 2 : per;
    for (int j = 0; j < total + idle_n; j++) begin
      if (j < total) begin
        jm     = j % pe;
        f.sync = (jm < syncw);
        f.done = (jm == pe - 1);
        f.busy = 1'b1;
        for (int k = 0; k < NCH; k++) begin
          w = ((j / pe) >= chg_per) ? wid_b[k] : wid_a[k];
          f.pulse[k] = ((jm >= dly[k]) && (jm < dly[k] + w)) ^ mask[k];
        end
      end else begin
        f.sync  = 1'b0;
        f.pulse = mask;
        f.done  = 1'b0;
        f.busy  = 1'b0;
      end
      sb.push_back(f);
    end
  endtask

  task automatic check_frame(input string tag, input int idx);
    frame_t f;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s[%0d] scoreboard empty observed=none expected=frame", tag, idx);
    end else begin
      f = sb.pop_front();
      chk($sformatf("%s[%0d].sync", tag, idx), 32'(Sync), 32'(f.sync));
      chk($sformatf("%s[%0d].pulse", tag, idx), 32'(Pulse), 32'(f.pulse));
      chk($sformatf("%s[%0d].done", tag, idx), 32'(period_done), 32'(f.done));
      chk($sformatf("%s[%0d].busy", tag, idx), 32'(busy), 32'(f.busy));
    end
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_frame(tag, i);
    end
  endtask

  task automatic wr(input int addr, input longint data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = CNT_W'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Write control, then step past the IDLE->RUN cycle so the next negedge shows counter 0.
  task automatic start(input int ctrl);
    wr(2, ctrl);
    @(negedge clk);
  endtask

  task automatic write_channels();
    for (int k = 0; k < NCH; k++) begin
      wr(4 + 2 * k, dly[k]);
      wr(5 + 2 * k, wid_a[k]);
    end
  endtask

  initial begin
    mask    = '0;
    chg_per = 1000;
    per     = 100;
    syncw   = 10;
    repeat (2) @(negedge clk);
    push_run(0, 1);
    check_frame("reset", 0);
    resetn = 1'b1;
    push_run(0, 3);
    drain("idle", 3);

    // Continuous run; ch1 width 5->15 mid-period, run cleared mid second period.
    dly     = '{20, 60, 90, 0};
    wid_a   = '{30, 5, 30, 0};
    wid_b   = wid_a;
    wid_b[1] = 15;
    chg_per = 1;
    wr(0, per);
    wr(1, syncw);
    write_channels();
    push_run(200, 5);
    start(1);
    for (int j = 0; j < 205; j++) begin
      @(negedge clk);
      check_frame("cont", j);
      if (j == 36) begin
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 24'd15;
      end else if (j == 150) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 24'd0;
      end else begin
        wr_en = 1'b0;
      end
    end
    wid_a   = wid_b;
    chg_per = 1000;

    // Burst of three 50-cycle periods, then must stay idle.
    per = 50;
    wr(0, per);
    wr(3, 3);
    push_run(150, 20);
    start(3);
    drain("burst", 170);

    // period=1 runs as 2; burst_count=0 gives one period; ch0 delay 0 rises with Sync.
    per      = 1;
    syncw    = 1;
    dly[0]   = 0;
    wid_a[0] = 1;
    wid_b    = wid_a;
    wr(0, per);
    wr(1, syncw);
    wr(4, 0);
    wr(5, 1);
    wr(3, 0);
    push_run(2, 6);
    start(3);
    drain("p1", 8);

    // Maximal delay and width on ch3 must never light up.
    per      = 100;
    syncw    = 10;
    dly[0]   = 20;
    wid_a[0] = 30;
    dly[3]   = 64'hFF_FFFF;
    wid_a[3] = 64'hFF_FFFF;
    wid_b    = wid_a;
    wr(0, per);
    wr(1, syncw);
    write_channels();
    wr(3, 1);
    push_run(100, 5);
    start(3);
    drain("ovf", 105);

`ifdef PULSE_POLARITY_EN
    wr(4 + 2 * NCH, 1);
    @(negedge clk);
    mask = 4'b0001;
    push_run(0, 3);
    drain("pol_idle", 3);
    push_run(100, 5);
    start(3);
    drain("pol_run", 105);
`endif

    // Reset while ch0 is high: outputs drop before the next clock edge.
    push_run(26, 0);
    start(1);
    drain("pre_rst", 26);
    #2 resetn = 1'b0;
    #1;
    mask = '0;
    push_run(0, 1);
    check_frame("rst_async", 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    push_run(0, 20);
    drain("post_rst", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
